// File: rtl/nco_multi.sv
// nco_multi -- multi-channel phase-accumulator NCO with quarter-wave LUT.
//
// Each channel has its own accumulator, frequency tuning word (FTW) and
// phase offset word (POW). Configuration is double-buffered: cfg_wr loads
// shadow registers, and cfg_commit copies every shadow register to the
// active set in one cycle. Adding cfg_sync to the commit also clears all
// accumulators and flushes the pipeline.
//
// Pipeline stages, each advancing only when ce is high:
//   S1 accumulator, S2 phase add, S3 quadrant/address, S4 LUT read,
//   S5 sign apply into sin_out/cos_out.
//
// Optional feature: define NCO_DITHER_EN to add per-channel LFSR phase
// dither ahead of truncation. Without it the outputs are the exact
// LUT/quadrant mapping.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   ce          sample enable
//   cfg_wr      shadow write strobe; cfg_ch selects the channel
//   cfg_ch      target channel (values >= CHANNELS are ignored)
//   cfg_ftw     frequency tuning word
//   cfg_pow     phase offset word
//   cfg_commit  shadow -> active copy for all channels
//   cfg_sync    with cfg_commit: clear accumulators, flush pipeline
//   sin_out     packed signed sine, channel 0 in the LSBs
//   cos_out     packed signed cosine, channel 0 in the LSBs
//   out_valid   output sample valid
module nco_multi #(
  parameter int CHANNELS   = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int POW_WIDTH  = 16,
  parameter int LUT_AW     = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ce,
  input  logic                           cfg_wr,
  input  logic [3:0]                     cfg_ch,
  input  logic [ACC_WIDTH-1:0]           cfg_ftw,
  input  logic [POW_WIDTH-1:0]           cfg_pow,
  input  logic                           cfg_commit,
  input  logic                           cfg_sync,
  output logic [CHANNELS*DATA_WIDTH-1:0] sin_out,
  output logic [CHANNELS*DATA_WIDTH-1:0] cos_out,
  output logic                           out_valid
);

  localparam int LUT_DEPTH = 1 << LUT_AW;
  localparam int POW_SHIFT = ACC_WIDTH - POW_WIDTH;
  localparam int PH_W      = LUT_AW + 2;
  localparam int TRUNC_W   = ACC_WIDTH - PH_W;
  localparam int AMP       = (1 << (DATA_WIDTH - 1)) - 1;

  // Elaboration-time sine; the argument never exceeds pi/2, where this
  // series is accurate to double precision.
  function automatic real sin_series(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 16; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Half-bin offset keeps every entry nonzero, so the quadrant mirroring
  // needs no special endpoint handling.
  function automatic logic [DATA_WIDTH-1:0] lut_entry(input int k);
    real x;
    x = 3.14159265358979323846 * (real'(k) + 0.5) / real'(2 * LUT_DEPTH);
    return DATA_WIDTH'($rtoi(real'(AMP) * sin_series(x) + 0.5));
  endfunction

  logic [DATA_WIDTH-1:0] lut_rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam logic [DATA_WIDTH-1:0] ENTRY = lut_entry(k);
    assign lut_rom[k] = ENTRY;
  end

  logic [ACC_WIDTH-1:0]  ftw_s     [CHANNELS];
  logic [ACC_WIDTH-1:0]  ftw_a     [CHANNELS];
  logic [ACC_WIDTH-1:0]  acc       [CHANNELS];
  logic [POW_WIDTH-1:0]  pow_s     [CHANNELS];
  logic [POW_WIDTH-1:0]  pow_a     [CHANNELS];
  logic [ACC_WIDTH-1:0]  dith      [CHANNELS];
  logic [ACC_WIDTH-1:0]  phase_sum [CHANNELS];
  logic [PH_W-1:0]       phase_r   [CHANNELS];
  logic [LUT_AW-1:0]     addr_s_r  [CHANNELS];
  logic [LUT_AW-1:0]     addr_c_r  [CHANNELS];
  logic [DATA_WIDTH-1:0] mag_s_r   [CHANNELS];
  logic [DATA_WIDTH-1:0] mag_c_r   [CHANNELS];
  logic [CHANNELS-1:0]   neg_s_r;
  logic [CHANNELS-1:0]   neg_c_r;
  logic [CHANNELS-1:0]   neg_s_d;
  logic [CHANNELS-1:0]   neg_c_d;
  logic [2:0]            fill_r;
  logic                  sync_commit;
  logic                  unused_phase_lsbs;

  assign sync_commit = cfg_commit & cfg_sync;

  // Configuration and accumulators. A write and a commit in the same cycle
  // commit the old shadow value, since the copy reads the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        ftw_s[c] <= '0;
        pow_s[c] <= '0;
        ftw_a[c] <= '0;
        pow_a[c] <= '0;
        acc[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (cfg_wr && cfg_ch == 4'(c)) begin
          ftw_s[c] <= cfg_ftw;
          pow_s[c] <= cfg_pow;
        end
        if (cfg_commit) begin
          ftw_a[c] <= ftw_s[c];
          pow_a[c] <= pow_s[c];
        end
        if (sync_commit)
          acc[c] <= '0;
        else if (ce)
          acc[c] <= acc[c] + ftw_a[c];
      end
    end
  end

`ifdef NCO_DITHER_EN
  // Dither covers at most the truncated bits; a 16-bit LFSR cannot supply
  // more than 16 of them.
  localparam int DITH_W = (TRUNC_W < 16) ? TRUNC_W : 16;

  logic [15:0] lfsr [CHANNELS];

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (rst || sync_commit)
        lfsr[c] <= 16'hACE1 + 16'(c);
      else if (ce)
        lfsr[c] <= {lfsr[c][14:0], lfsr[c][15] ^ lfsr[c][13] ^ lfsr[c][12] ^ lfsr[c][10]};
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++)
      dith[c] = ACC_WIDTH'(lfsr[c][15 -: DITH_W]);
  end
`else
  always_comb begin
    for (int c = 0; c < CHANNELS; c++)
      dith[c] = '0;
  end
`endif

  always_comb begin
    for (int c = 0; c < CHANNELS; c++)
      phase_sum[c] = acc[c] + (ACC_WIDTH'(pow_a[c]) << POW_SHIFT) + dith[c];
  end

  // Phase bits below the LUT address are deliberately dropped.
  always_comb begin
    unused_phase_lsbs = 1'b0;
    for (int c = 0; c < CHANNELS; c++)
      unused_phase_lsbs = unused_phase_lsbs ^ (^phase_sum[c][TRUNC_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        phase_r[c]  <= '0;
        addr_s_r[c] <= '0;
        addr_c_r[c] <= '0;
        mag_s_r[c]  <= '0;
        mag_c_r[c]  <= '0;
      end
      neg_s_r   <= '0;
      neg_c_r   <= '0;
      neg_s_d   <= '0;
      neg_c_d   <= '0;
      sin_out   <= '0;
      cos_out   <= '0;
      fill_r    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (ce) begin
        for (int c = 0; c < CHANNELS; c++) begin
          phase_r[c] <= phase_sum[c][ACC_WIDTH-1 -: PH_W];
          // The quadrant is phase_r[top:top-1]. Odd quadrants read the table
          // mirrored, and quadrants 2-3 negate. Cosine is the same lookup
          // one quadrant ahead.
          addr_s_r[c] <= phase_r[c][LUT_AW-1:0] ^ {LUT_AW{phase_r[c][LUT_AW]}};
          addr_c_r[c] <= phase_r[c][LUT_AW-1:0] ^ {LUT_AW{~phase_r[c][LUT_AW]}};
          neg_s_r[c]  <= phase_r[c][LUT_AW+1];
          neg_c_r[c]  <= phase_r[c][LUT_AW+1] ^ phase_r[c][LUT_AW];
          mag_s_r[c]  <= lut_rom[addr_s_r[c]];
          mag_c_r[c]  <= lut_rom[addr_c_r[c]];
          neg_s_d[c]  <= neg_s_r[c];
          neg_c_d[c]  <= neg_c_r[c];
          sin_out[c*DATA_WIDTH +: DATA_WIDTH] <= neg_s_d[c] ? -mag_s_r[c] : mag_s_r[c];
          cos_out[c*DATA_WIDTH +: DATA_WIDTH] <= neg_c_d[c] ? -mag_c_r[c] : mag_c_r[c];
        end
      end
      // fill_r counts accepted samples since reset or a sync commit. The
      // accumulator value present at the first ce is itself a sample, so the
      // output is valid from the fourth ce onward.
      if (sync_commit) begin
        fill_r    <= '0;
        out_valid <= 1'b0;
      end else if (ce) begin
        fill_r    <= {fill_r[1:0], 1'b1};
        out_valid <= fill_r[2];
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nco_multi.sv
module tb_nco_multi;
  localparam int CH = 4;
  localparam int AW = 32;
  localparam int PW = 16;
  localparam int LA = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst, ce, cfg_wr, cfg_commit, cfg_sync;
  logic [3:0]       cfg_ch;
  logic [AW-1:0]    cfg_ftw;
  logic [PW-1:0]    cfg_pow;
  logic [CH*DW-1:0] sin_out, cos_out;
  logic             out_valid;

  always #5 clk = ~clk;

  nco_multi #(.CHANNELS(CH), .ACC_WIDTH(AW), .POW_WIDTH(PW), .LUT_AW(LA), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_ftw(cfg_ftw), .cfg_pow(cfg_pow), .cfg_commit(cfg_commit), .cfg_sync(cfg_sync),
    .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: sample stream with a fixed 4-ce delay.
  int               lut [1024];
  logic [31:0]      m_acc [CH], m_ftw_s [CH], m_ftw_a [CH];
  logic [15:0]      m_pow_s [CH], m_pow_a [CH];
  logic [CH*DW-1:0] q_sin [$], q_cos [$];
  logic [CH*DW-1:0] exp_sin, exp_cos;
  bit               exp_valid;

  typedef struct packed {
    logic [31:0]      ftw;
    logic [15:0]      pow;
    logic [3:0][15:0] s;
    logic [3:0][15:0] c;
  } vec_t;
  vec_t tv [6];

  function automatic int amp(input logic [31:0] p, input int qoff);
    int q, idx;
    q   = (int'(p[31:30]) + qoff) % 4;
    idx = int'(p[29:20]);
    case (q)
      0:       return lut[idx];
      1:       return lut[1023 - idx];
      2:       return -lut[idx];
      default: return -lut[1023 - idx];
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [CH*DW-1:0] s_v, c_v;
    logic [31:0] p;
    int ci;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_acc[c] = '0; m_ftw_s[c] = '0; m_ftw_a[c] = '0; m_pow_s[c] = '0; m_pow_a[c] = '0;
      end
      q_sin.delete(); q_cos.delete();
      exp_sin = '0; exp_cos = '0; exp_valid = 0;
      return;
    end
    if (cfg_commit && cfg_sync) begin
      q_sin.delete(); q_cos.delete();
      exp_valid = 0;
    end else if (ce) begin
      for (int c = 0; c < CH; c++) begin
        p = m_acc[c] + {m_pow_a[c], 16'h0000};
        s_v[c*DW +: DW] = 16'(amp(p, 0));
        c_v[c*DW +: DW] = 16'(amp(p, 1));
      end
      q_sin.push_back(s_v);
      q_cos.push_back(c_v);
      if (q_sin.size() > 3) begin
        exp_sin   = q_sin.pop_front();
        exp_cos   = q_cos.pop_front();
        exp_valid = 1;
      end else begin
        exp_valid = 0;
      end
    end else begin
      exp_valid = 0;
    end
    for (int c = 0; c < CH; c++) begin
      if (cfg_commit && cfg_sync) m_acc[c] = '0;
      else if (ce)                m_acc[c] = m_acc[c] + m_ftw_a[c];
    end
    if (cfg_commit)
      for (int c = 0; c < CH; c++) begin
        m_ftw_a[c] = m_ftw_s[c];
        m_pow_a[c] = m_pow_s[c];
      end
    if (cfg_wr && cfg_ch < CH) begin
      ci = int'(cfg_ch);
      m_ftw_s[ci] = cfg_ftw;
      m_pow_s[ci] = cfg_pow;
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit w, input logic [3:0] ch,
                     input logic [31:0] f, input logic [15:0] pw, input bit cm, input bit sy);
    rst = r; ce = e; cfg_wr = w; cfg_ch = ch; cfg_ftw = f; cfg_pow = pw;
    cfg_commit = cm; cfg_sync = sy;
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    if (exp_valid || r) begin
      chk("sin_out", sin_out, exp_sin);
      chk("cos_out", cos_out, exp_cos);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 4'd0, 32'd0, 16'd0, 0, 0);
  endtask

  task automatic wr(input logic [3:0] ch, input logic [31:0] f, input logic [15:0] pw, input bit e);
    cyc(0, e, 1, ch, f, pw, 0, 0);
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    do begin
      cyc(0, 1, 0, 4'd0, 32'd0, 16'd0, 0, 0);
      n++;
    end while (!out_valid && n < 10);
    chk(nm, 64'(n), 64'd4);
  endtask

  task automatic set_vec(input int i, input logic [31:0] f, input logic [15:0] pw,
                         input int s0, input int s1, input int s2, input int s3,
                         input int c0, input int c1, input int c2, input int c3);
    tv[i].ftw = f;
    tv[i].pow = pw;
    tv[i].s   = {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
    tv[i].c   = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endtask

  initial begin
    for (int k = 0; k < 1024; k++)
      lut[k] = $rtoi(32767.0 * $sin(3.14159265358979323846 * (real'(k) + 0.5) / 2048.0) + 0.5);

    // ch0 expected four-sample sequences after a sync commit
    set_vec(0, 32'h4000_0000, 16'h0000,  25, 32767,   -25, -32767,  32767,   -25, -32767,    25);
    set_vec(1, 32'hC000_0000, 16'h0000,  25, -32767,  -25,  32767,  32767,    25, -32767,   -25);
    set_vec(2, 32'h0000_0000, 16'h0000,  25,    25,    25,     25,  32767, 32767,  32767, 32767);
    set_vec(3, 32'h4000_0000, 16'h4000, 32767,  -25, -32767,    25,    -25, -32767,   25, 32767);
    set_vec(4, 32'h4000_0000, 16'h8000, -25, -32767,   25,  32767, -32767,    25,  32767,  -25);
    set_vec(5, 32'h0000_0000, 16'h0010,  75,    75,    75,     75,  32767, 32767,  32767, 32767);

    // reset held with ce high, then fill latency
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 4'd0, 32'd0, 16'd0, 0, 0);
    wait_valid("reset_fill");

    for (int i = 0; i < 6; i++) begin
      wr(4'd0, tv[i].ftw, tv[i].pow, 0);
      cyc(0, 0, 0, 4'd0, 32'd0, 16'd0, 1, 1);
      wait_valid("tbl_fill");
      for (int j = 0; j < 4; j++) begin
        chk("tbl_sin", 64'(sin_out[15:0]), 64'(tv[i].s[j]));
        chk("tbl_cos", 64'(cos_out[15:0]), 64'(tv[i].c[j]));
        cyc(0, 1, 0, 4'd0, 32'd0, 16'd0, 0, 0);
      end
    end

    // phase offset: ch1 ahead by 90 then 180 degrees
    wr(4'd0, 32'h4000_0000, 16'h0000, 1);
    wr(4'd1, 32'h4000_0000, 16'h4000, 1);
    cyc(0, 1, 0, 4'd0, 32'd0, 16'd0, 1, 1);
    run(12);
    wr(4'd1, 32'h4000_0000, 16'h8000, 1);
    cyc(0, 1, 0, 4'd0, 32'd0, 16'd0, 1, 1);
    run(12);

    // coherent commit: staged writes, an out-of-range channel, single commit
    wr(4'd2, 32'h4000_0000, 16'h1234, 1);
    wr(4'd3, 32'h4000_0000, 16'h0000, 1);
    cyc(0, 1, 0, 4'd0, 32'd0, 16'd0, 1, 1);
    run(8);
    for (int c = 0; c < CH; c++) wr(4'(c), 32'h2000_0000 * (c + 1), 16'(c * 16'h1000), 1);
    wr(4'd9, 32'h1357_9BDF, 16'hFFFF, 1);
    run(6);
    cyc(0, 1, 1, 4'd0, 32'h0800_0000, 16'h0000, 1, 0);   // write + commit same cycle
    run(12);
    cyc(0, 1, 0, 4'd0, 32'd0, 16'd0, 1, 0);
    run(8);

    // ce gating 1-of-3
    for (int k = 0; k < 36; k++) cyc(0, (k % 3) == 0, 0, 4'd0, 32'd0, 16'd0, 0, 0);

    // sync commit mid-stream, then reset mid-stream
    cyc(0, 1, 0, 4'd0, 32'd0, 16'd0, 1, 1);
    wait_valid("sync_refill");
    cyc(1, 1, 0, 4'd0, 32'd0, 16'd0, 0, 0);
    wait_valid("rst_refill");

    // randomized traffic against the model
    for (int k = 0; k < 500; k++) begin
      bit e, w, cm, sy, r;
      e  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 2) == 0);
      cm = ($urandom_range(0, 9) == 0);
      sy = cm && ($urandom_range(0, 2) == 0);
      r  = ($urandom_range(0, 149) == 0);
      cyc(r, e, w, 4'($urandom_range(0, 5)), $urandom, 16'($urandom), cm, sy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
